// File: rtl/db_multi_fsmd_pkg.sv
// db_multi_fsmd_pkg: shared debounce state encodings used by every debounce block
package db_multi_fsmd_pkg;
    // bit 0 marks a wait state
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT0 = 2'b01,
        ONE   = 2'b10,
        WAIT1 = 2'b11
    } db_state_e;
endpackage

// File: rtl/db_multi_fsmd_chan.sv
// db_chan: one debounce channel, two-flop synchroniser feeding a ZERO/WAIT1/ONE/WAIT0 FSMD
//   iCLK clock, iRESET async active-high reset, iSW raw switch
//   oDB debounced level, oRISE/oFALL one-cycle edge pulses, oBUSY channel in a wait state
module db_chan
    import db_multi_fsmd_pkg::*;
#(
    parameter int N     = 21,
    parameter bit EARLY = 1'b0
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iSW,
    output logic oDB,
    output logic oRISE,
    output logic oFALL,
    output logic oBUSY
);
    logic         sw1_q, s_q, db_prev_q;
    db_state_e    state_q, state_d;
    logic [N-1:0] q_q, q_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        case (state_q)
            ZERO: if (s_q) begin
                state_d = WAIT1;
                q_d     = '1;
            end
            ONE: if (!s_q) begin
                state_d = WAIT0;
                q_d     = '1;
            end
            WAIT1, WAIT0: begin
                // delayed mode aborts when s falls back to the level being left
                if (!EARLY && s_q == (state_q == WAIT0))
                    state_d = state_q == WAIT1 ? ZERO : ONE;
                else if (q_q == N'(1))
                    state_d = state_q == WAIT1 ? ONE : ZERO;
                else
                    q_d = q_q - N'(1);
            end
            default: state_d = ZERO;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            sw1_q     <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= ZERO;
            q_q       <= '0;
            db_prev_q <= 1'b0;
        end else begin
            sw1_q     <= iSW;
            s_q       <= sw1_q;
            state_q   <= state_d;
            q_q       <= q_d;
            db_prev_q <= oDB;
        end
    end

    // delayed: high in ONE/WAIT0; early: high in WAIT1/ONE
    assign oDB   = EARLY ? state_q[1] : ^state_q;
    assign oRISE = oDB & ~db_prev_q;
    assign oFALL = ~oDB & db_prev_q;
    assign oBUSY = state_q[0];
endmodule

// File: rtl/db_multi_fsmd.sv
// db_multi_fsmd: W independent switch debouncers with edge pulses and a shared busy flag
//   iCLK clock, iRESET async active-high reset, iSW[W] raw switches
//   oDB[W] debounced levels, oRISE/oFALL[W] edge pulses, oBUSY any channel waiting
module db_multi_fsmd #(
    parameter int W     = 4,
    parameter int N     = 21,
    parameter bit EARLY = 1'b0
) (
    input  logic         iCLK,
    input  logic         iRESET,
    input  logic [W-1:0] iSW,
    output logic [W-1:0] oDB,
    output logic [W-1:0] oRISE,
    output logic [W-1:0] oFALL,
    output logic         oBUSY
);
    logic [W-1:0] busy;

    for (genvar i = 0; i < W; i++) begin : g_chan
        db_chan #(.N(N), .EARLY(EARLY)) u_chan (
            .iCLK  (iCLK),
            .iRESET(iRESET),
            .iSW   (iSW[i]),
            .oDB   (oDB[i]),
            .oRISE (oRISE[i]),
            .oFALL (oFALL[i]),
            .oBUSY (busy[i])
        );
    end

    assign oBUSY = |busy;
endmodule

// File: tb/tb_db_multi_fsmd.sv
// tb_db_multi_fsmd: checks delayed and early debouncers against a run-length model plus literal latencies
module tb_db_multi_fsmd;
    localparam int W   = 4;
    localparam int N   = 3;
    localparam int WIN = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] sw_d = '0, sw_e = '0;
    logic [W-1:0] db_d, rise_d, fall_d, db_e, rise_e, fall_e;
    logic busy_d, busy_e;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    db_multi_fsmd #(.W(W), .N(N), .EARLY(1'b0)) dut_d (
        .iCLK(clk), .iRESET(rst), .iSW(sw_d),
        .oDB(db_d), .oRISE(rise_d), .oFALL(fall_d), .oBUSY(busy_d)
    );
    db_multi_fsmd #(.W(W), .N(N), .EARLY(1'b1)) dut_e (
        .iCLK(clk), .iRESET(rst), .iSW(sw_e),
        .oDB(db_e), .oRISE(rise_e), .oFALL(fall_e), .oBUSY(busy_e)
    );

    // delayed: output adopts s after s has differed from it for 2^N consecutive edges
    // early: output adopts s at once, then is locked for WIN edges
    logic [W-1:0] m1_d = '0, ms_d = '0, mdb_d = '0, mprev_d = '0;
    logic [W-1:0] m1_e = '0, ms_e = '0, mdb_e = '0, mprev_e = '0;
    int run [W] = '{default: 0};
    int lock [W] = '{default: 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_d <= '0; ms_d <= '0; mdb_d <= '0; mprev_d <= '0;
            m1_e <= '0; ms_e <= '0; mdb_e <= '0; mprev_e <= '0;
            run  <= '{default: 0};
            lock <= '{default: 0};
        end else begin
            for (int i = 0; i < W; i++) begin
                run[i] <= (ms_d[i] == mdb_d[i] || run[i] == WIN) ? 0 : run[i] + 1;
                if (ms_d[i] != mdb_d[i] && run[i] == WIN) mdb_d[i] <= ms_d[i];
                lock[i] <= lock[i] > 0 ? lock[i] - 1 : (ms_e[i] != mdb_e[i] ? WIN : 0);
                if (lock[i] == 0 && ms_e[i] != mdb_e[i]) mdb_e[i] <= ms_e[i];
            end
            mprev_d <= mdb_d; mprev_e <= mdb_e;
            m1_d <= sw_d; ms_d <= m1_d;
            m1_e <= sw_e; ms_e <= m1_e;
        end
    end

    function automatic int any_active(input int a [W]);
        int r = 0;
        for (int i = 0; i < W; i++) if (a[i] != 0) r = 1;
        return r;
    endfunction

    task automatic chk_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk_v("model_db_d", db_d, mdb_d);
        chk_v("model_rise_d", rise_d, mdb_d & ~mprev_d);
        chk_v("model_fall_d", fall_d, ~mdb_d & mprev_d);
        chk_i("model_busy_d", int'(busy_d), any_active(run));
        chk_v("model_db_e", db_e, mdb_e);
        chk_v("model_rise_e", rise_e, mdb_e & ~mprev_e);
        chk_v("model_fall_e", fall_e, ~mdb_e & mprev_e);
        chk_i("model_busy_e", int'(busy_e), any_active(lock));
    end

    int first_d, first_e, busy_n, rise_n, fall_n, rise_d0, other, low_after, hit, mixed_d, mixed_e;
    logic [2*W-1:0] pulse_d, pulse_e;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk_v("reset_db_d", db_d, '0);
        chk_v("reset_db_e", db_e, '0);
        chk_i("reset_busy", int'(busy_d | busy_e), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // delayed ch0 rise, early ch2 bouncing rise
        first_d = 0; first_e = 0; busy_n = 0; rise_n = 0; fall_n = 0; rise_d0 = 0; other = 0; low_after = 0;
        for (int c = 0; c < 20; c++) begin
            sw_d[0] = 1'b1;
            sw_e[2] = c < 6 ? ~c[0] : 1'b1;
            @(posedge clk); #1;
            if (db_d[0] && first_d == 0) first_d = c + 1;
            if (db_e[2] && first_e == 0) first_e = c + 1;
            if (first_e != 0 && !db_e[2]) low_after++;
            busy_n += int'(busy_d);
            rise_n += int'(rise_e[2]);
            fall_n += int'(fall_e[2]);
            rise_d0 += int'(rise_d[0]);
            if (db_d[3:1] != 3'b000) other++;
            @(negedge clk);
        end
        chk_i("delayed_latency", first_d, 10);
        chk_i("delayed_busy_len", busy_n, 7);
        chk_i("delayed_rise_cnt", rise_d0, 1);
        chk_i("delayed_others_quiet", other, 0);
        chk_i("early_latency", first_e, 3);
        chk_i("early_stays_high", low_after, 0);
        chk_i("early_rise_cnt", rise_n, 1);
        chk_i("early_fall_cnt", fall_n, 0);

        // short pulse on delayed ch1
        busy_n = 0; hit = 0;
        for (int c = 0; c < 16; c++) begin
            sw_d[1] = c < 4;
            @(posedge clk); #1;
            busy_n += int'(busy_d);
            if (db_d[1] | rise_d[1] | fall_d[1]) hit++;
            @(negedge clk);
        end
        chk_i("short_pulse_busy", busy_n, 4);
        chk_i("short_pulse_quiet", hit, 0);

        // all channels toggle together: d 0001->1110, e 0100->1011
        sw_d = 4'b1110; sw_e = 4'b1011;
        first_d = 0; first_e = 0; mixed_d = 0; mixed_e = 0; pulse_d = '0; pulse_e = '0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (first_d == 0 && db_d == 4'b1110) begin first_d = c + 1; pulse_d = {rise_d, fall_d}; end
            if (first_e == 0 && db_e == 4'b1011) begin first_e = c + 1; pulse_e = {rise_e, fall_e}; end
            if (db_d != 4'b0001 && db_d != 4'b1110) mixed_d++;
            if (db_e != 4'b0100 && db_e != 4'b1011) mixed_e++;
        end
        chk_i("toggle_latency_d", first_d, 10);
        chk_i("toggle_latency_e", first_e, 3);
        chk_i("toggle_pulses_d", int'(pulse_d), int'(8'b1110_0001));
        chk_i("toggle_pulses_e", int'(pulse_e), int'(8'b1011_0100));
        chk_i("toggle_together", mixed_d + mixed_e, 0);

        // async reset mid-WAIT1 on ch3
        @(negedge clk);
        sw_d = '0; sw_e = '0;
        repeat (16) @(negedge clk);
        sw_d[3] = 1'b1; sw_e[3] = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        chk_i("pre_reset_busy", int'(busy_d), 1);
        chk_i("pre_reset_early_db3", int'(db_e[3]), 1);
        rst = 1'b1;
        #1;
        chk_v("async_reset_db_d", db_d, '0);
        chk_v("async_reset_db_e", db_e, '0);
        chk_v("async_reset_pulses", rise_d | fall_d | rise_e | fall_e, '0);
        chk_i("async_reset_busy", int'(busy_d | busy_e), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        first_d = 0; first_e = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c == 0) chk_v("release_no_pulse", rise_d | fall_d | rise_e | fall_e, '0);
            if (db_d[3] && first_d == 0) first_d = c + 1;
            if (db_e[3] && first_e == 0) first_e = c + 1;
        end
        chk_i("post_reset_latency_d", first_d, 10);
        chk_i("post_reset_latency_e", first_e, 3);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/db_multi_fsmd.md
DB_MULTI_FSMD -- requirements
Module: db_multi_fsmd

Interface
REQ-001 Parameter W, default 4: number of independent debounce channels (W >= 1).
REQ-002 Parameter N, default 21: counter bits; stability window is 2^N-1 cycles (N >= 2; 21 gives about 40 ms at 50 MHz).
REQ-003 Parameter EARLY, default 0: 0 = delayed mode (output follows input after stability); 1 = early mode (output follows the first edge, then ignores the input for the window).
REQ-004 Port iCLK  input  1  single clock; all state changes on its rising edge.
REQ-005 Port iRESET  input  1  asynchronous, active-high reset.
REQ-006 Port iSW  input  W  raw switch inputs, asynchronous to iCLK; bit i belongs to channel i.
REQ-007 Port oDB  output  W  debounced level per channel.
REQ-008 Port oRISE  output  W  one-cycle pulse per channel on each 0->1 transition of oDB.
REQ-009 Port oFALL  output  W  one-cycle pulse per channel on each 1->0 transition of oDB.
REQ-010 Port oBUSY  output  1  high while any channel is in a wait state.

Function
REQ-011 Each iSW bit SHALL pass through a two-flop synchroniser; the FSM sees only the second flop (s).
REQ-012 Each channel SHALL be an FSMD with states ZERO, WAIT1, ONE, WAIT0 and an N-bit down-counter q.
REQ-013 ZERO: s=1 -> WAIT1, q loaded with all ones; otherwise hold.
REQ-014 ONE: s=0 -> WAIT0, q loaded with all ones; otherwise hold.
REQ-015 Delayed mode, WAIT1: s=0 -> ZERO (abort, q unchanged/don't-care); s=1 and q=1 -> ONE; s=1 and q>1 -> q decrements by 1.
REQ-016 Delayed mode, WAIT0: mirror of REQ-015 (s=1 aborts to ONE; s=0 and q=1 -> ZERO).
REQ-017 Early mode, WAIT1/WAIT0: s is ignored; q decrements each cycle; q=1 -> ONE/ZERO respectively.
REQ-018 Delayed mode oDB: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-019 Early mode oDB: 1 in WAIT1 and ONE, 0 in WAIT0 and ZERO.
REQ-020 Latency from an iSW edge, held stable, to the changed oDB: 2^N+2 rising edges in delayed mode, 3 rising edges in early mode.
REQ-021 A pulse shorter than the window in delayed mode SHALL produce no oDB change and no oRISE/oFALL.
REQ-022 oRISE[i]/oFALL[i] SHALL be high exactly during the first cycle of the new oDB[i] level, derived from a registered copy of oDB.
REQ-023 Counter arithmetic is unsigned N-bit; q never decrements below 1 in a wait state, and no wrap-around is permitted.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels are processed in the same cycle.
REQ-025 oBUSY = OR over channels of (state is WAIT1 or WAIT0), taken from registered state (Moore).
REQ-026 Illegal state encodings SHALL return to ZERO on the next edge.

Reset
REQ-027 iRESET high SHALL immediately clear, regardless of clock: synchroniser flops, state (to ZERO), q, and the registered oDB copy, all to 0.
REQ-028 During and after reset: oDB=0, oRISE=0, oFALL=0, oBUSY=0; no pulse is generated on reset release.
REQ-029 Reset asserted mid-wait SHALL abort the window; with iSW held high through reset, the channel debounces afresh from ZERO.

Structure
REQ-030 The state encodings (ZERO=00, WAIT0=01, ONE=10, WAIT1=11) SHALL live in a shared db package/include used by all debounce blocks.
REQ-031 The per-channel logic SHALL be a sub-module db_chan (parameters N and EARLY) instantiated W times by a generate loop; the top adds only the oBUSY reduction.

Verification (bench: W=4, N=3, window 7)
REQ-032 Delayed: iSW[0] 0->1 held -> oDB[0] high after 10 edges, oRISE[0] one cycle, oBUSY high for 7 cycles, other channels stay 0.
REQ-033 Delayed: iSW[1] high for 4 cycles then low -> oDB[1], oRISE[1], oFALL[1] remain 0; oBUSY pulses for 4 cycles.
REQ-034 Early: iSW[2] 0->1 then bounces 1/0 every cycle for 6 cycles, then settles at 1 -> oDB[2] high after 3 edges and stays high; exactly one oRISE, no oFALL.
REQ-035 All four channels toggle on the same edge -> all four oDB change on the same cycle with simultaneous pulses.
REQ-036 iRESET pulsed asynchronously mid-WAIT1 with iSW[3]=1 -> outputs are 0 immediately; oDB[3] rises 10 edges after reset release.
